// File: rtl/ramb4_s4_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ramb4_s4_arb_if                                            |
// | Description : Bundle of the two requester ports and the RAMB4_S4 port     |
// |               driven by ramb4_s4_arb.                                    |
// |   Requester x (a/b): req_x, we_x, addr_x[9:0], di_x[3:0] -> arbiter       |
// |                      gnt_x, rvalid_x, rdata_x[3:0]       <- arbiter       |
// |   RAM side         : ram_addr[9:0], ram_di[3:0], ram_en, ram_we, ram_rst  |
// |                      <- arbiter; ram_do[3:0] -> arbiter                  |
// |   Status           : busy <- arbiter                                     |
// |   Modports: slave = arbiter side, master = clients/RAM side.             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface ramb4_s4_arb_if;
    logic       req_a;
    logic       we_a;
    logic [9:0] addr_a;
    logic [3:0] di_a;
    logic       gnt_a;
    logic       rvalid_a;
    logic [3:0] rdata_a;

    logic       req_b;
    logic       we_b;
    logic [9:0] addr_b;
    logic [3:0] di_b;
    logic       gnt_b;
    logic       rvalid_b;
    logic [3:0] rdata_b;

    logic [9:0] ram_addr;
    logic [3:0] ram_di;
    logic       ram_en;
    logic       ram_we;
    logic       ram_rst;
    logic [3:0] ram_do;

    logic       busy;

    modport slave (
        input  req_a, we_a, addr_a, di_a,
        input  req_b, we_b, addr_b, di_b,
        input  ram_do,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output ram_addr, ram_di, ram_en, ram_we, ram_rst,
        output busy
    );

    modport master (
        output req_a, we_a, addr_a, di_a,
        output req_b, we_b, addr_b, di_b,
        output ram_do,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  ram_addr, ram_di, ram_en, ram_we, ram_rst,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/ramb4_s4_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ramb4_s4_arb                                               |
// | Description : Two-requester arbiter/sequencer for one single-port        |
// |               1024x4 block RAM. One access per cycle is granted to A or  |
// |               B (round-robin or fixed priority on a tie), issued to the  |
// |               RAM from registers, and read data is returned to the       |
// |               winner three cycles after its grant.                       |
// | Ports       : clk_i   - clock, rising edge                               |
// |               rst_n_i - synchronous active-low reset                     |
// |               bus     - ramb4_s4_arb_if.slave (requesters A/B, RAM port, |
// |                         busy)                                            |
// | Parameters  : ARB_MODE - 0 round-robin on tie, 1 A always wins a tie     |
// |               CLR_DATA - word written by the clear sweep                 |
// | Macro       : RAMB4_S4_ARB_CLEAR_EN - when defined, a 1024-cycle sweep   |
// |               writes CLR_DATA to every address after reset.             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module ramb4_s4_arb #(
    parameter int         ARB_MODE = 0,
    parameter logic [3:0] CLR_DATA = 4'h0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    ramb4_s4_arb_if.slave bus
);

    logic       gnt_a;
    logic       gnt_b;
    logic       busy;
    logic       issue_rd;
    logic       clearing;
    logic [9:0] clr_addr;

    logic       last_b_q;      // 1 = B received the most recent grant
    logic       last_b_d;

    logic [9:0] ram_addr_q, ram_addr_d;
    logic [3:0] ram_di_q,   ram_di_d;
    logic       ram_en_q,   ram_en_d;
    logic       ram_we_q,   ram_we_d;
    logic       ram_rst_q;

    // In-flight read tags: bit 0 = issued last edge, bit 1 = RAM_DO valid now
    logic [1:0] tag_v_q, tag_v_d;
    logic [1:0] tag_b_q, tag_b_d;

    logic       rvalid_a_q, rvalid_a_d;
    logic       rvalid_b_q, rvalid_b_d;
    logic [3:0] rdata_a_q,  rdata_a_d;
    logic [3:0] rdata_b_q,  rdata_b_d;

`ifdef RAMB4_S4_ARB_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t     state_q;
    logic [9:0] clr_cnt_q;

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;

    // Sweep one address per cycle; leave CLEAR once address 1023 is issued.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 10'd1;
            if (clr_cnt_q == 10'h3FF) begin
                state_q <= ST_RUN;
            end
        end
    end
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = !rst_n_i || clearing;

    // Tie-break: ARB_MODE=1 always favours A; otherwise favour whoever did
    // not win last time.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!busy) begin
            if (bus.req_a && !bus.req_b) begin
                gnt_a = 1'b1;
            end else if (!bus.req_a && bus.req_b) begin
                gnt_b = 1'b1;
            end else if (bus.req_a && bus.req_b) begin
                if ((ARB_MODE != 0) || last_b_q) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end
        end
    end

    // RAM port next state: address/data hold when idle, EN/WE drop.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        last_b_d   = last_b_q;
        if (clearing) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = clr_addr;
            ram_di_d   = CLR_DATA;
        end else if (gnt_a) begin
            ram_en_d   = 1'b1;
            ram_we_d   = bus.we_a;
            ram_addr_d = bus.addr_a;
            ram_di_d   = bus.di_a;
            last_b_d   = 1'b0;
        end else if (gnt_b) begin
            ram_en_d   = 1'b1;
            ram_we_d   = bus.we_b;
            ram_addr_d = bus.addr_b;
            ram_di_d   = bus.di_b;
            last_b_d   = 1'b1;
        end
    end

    assign issue_rd   = (gnt_a && !bus.we_a) || (gnt_b && !bus.we_b);
    assign tag_v_d    = {tag_v_q[0], issue_rd};
    assign tag_b_d    = {tag_b_q[0], gnt_b};

    // The tag in stage 1 marks the cycle in which RAM_DO carries the read.
    assign rvalid_a_d = tag_v_q[1] && !tag_b_q[1];
    assign rvalid_b_d = tag_v_q[1] &&  tag_b_q[1];
    assign rdata_a_d  = rvalid_a_d ? bus.ram_do : rdata_a_q;
    assign rdata_b_d  = rvalid_b_d ? bus.ram_do : rdata_b_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_rst_q  <= 1'b1;
            last_b_q   <= 1'b1;
            tag_v_q    <= '0;
            tag_b_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_rst_q  <= 1'b0;
            last_b_q   <= last_b_d;
            tag_v_q    <= tag_v_d;
            tag_b_q    <= tag_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_di   = ram_di_q;
    assign bus.ram_en   = ram_en_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_rst  = ram_rst_q;
    assign bus.busy     = busy;

endmodule
`default_nettype wire

// File: tb/tb_ramb4_s4_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ramb4_s4_arb                                            |
// | Description : Self-checking bench for ramb4_s4_arb. dut0 (ARB_MODE=0)    |
// |               carries most scenarios against a reference model of the    |
// |               arbitration rules and memory contents; dut1 (ARB_MODE=1)   |
// |               covers fixed priority. Both share clock and reset and each |
// |               has its own behavioural write-first RAM.                   |
// | Macro       : RAMB4_S4_ARB_CLEAR_EN enables the clear-sweep scenario.    |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ramb4_s4_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    ramb4_s4_arb_if bus0();
    ramb4_s4_arb_if bus1();

    ramb4_s4_arb #(.ARB_MODE(0), .CLR_DATA(4'h3)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
    ramb4_s4_arb #(.ARB_MODE(1), .CLR_DATA(4'h3)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

    // Behavioural RAMB4_S4: synchronous, write-first, RST clears the output.
    logic [3:0] mem0 [1024];
    logic [3:0] mem1 [1024];
    always @(posedge clk) begin
        if (bus0.ram_en) begin
            if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_di;
            bus0.ram_do <= bus0.ram_rst ? 4'h0 : (bus0.ram_we ? bus0.ram_di : mem0[bus0.ram_addr]);
        end
    end
    always @(posedge clk) begin
        if (bus1.ram_en) begin
            if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_di;
            bus1.ram_do <= bus1.ram_rst ? 4'h0 : (bus1.ram_we ? bus1.ram_di : mem1[bus1.ram_addr]);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Requester stimulus for dut0
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [9:0] a_addr = '0, b_addr = '0;
    logic [3:0] a_di = '0, b_di = '0;

    // Observed dut0 values for the current step
    logic       o_ga, o_gb, o_va, o_vb, o_busy;
    logic [3:0] o_da, o_db;

    // Reference model state
    logic [3:0] ref0 [1024];
    logic       m_last_b = 1'b1;
    int         clr_left = 0;
    logic       e_ga, e_gb, e_va = 1'b0, e_vb = 1'b0, e_busy;
    logic [3:0] e_da = 4'h0, e_db = 4'h0;
    logic       dv  [3] = '{1'b0, 1'b0, 1'b0};
    logic       did [3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] dd  [3];

    // One clock cycle on dut0: drive requests, sample grants mid-cycle,
    // advance the model, sample registered outputs just after the edge.
    task automatic step0();
        logic ok;
        @(negedge clk);
        bus0.req_a = a_req; bus0.we_a = a_we; bus0.addr_a = a_addr; bus0.di_a = a_di;
        bus0.req_b = b_req; bus0.we_b = b_we; bus0.addr_b = b_addr; bus0.di_b = b_di;
        #1;
        o_ga = bus0.gnt_a;
        o_gb = bus0.gnt_b;
        ok   = rst_n && (clr_left == 0);
        e_ga = ok && a_req && (!b_req || m_last_b);
        e_gb = ok && b_req && !e_ga;
        if (e_ga || e_gb) m_last_b = e_gb;
        dv[2]  = (e_ga && !a_we) || (e_gb && !b_we);
        did[2] = e_gb;
        dd[2]  = e_ga ? ref0[a_addr] : ref0[b_addr];
        if (e_ga && a_we) ref0[a_addr] = a_di;
        if (e_gb && b_we) ref0[b_addr] = b_di;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) dv[i] = 1'b0;
            m_last_b = 1'b1;
            e_va = 1'b0; e_vb = 1'b0; e_da = 4'h0; e_db = 4'h0;
`ifdef RAMB4_S4_ARB_CLEAR_EN
            clr_left = 1024;
`endif
        end else begin
            e_va = dv[0] && !did[0];
            e_vb = dv[0] &&  did[0];
            if (e_va) e_da = dd[0];
            if (e_vb) e_db = dd[0];
            if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0) for (int i = 0; i < 1024; i++) ref0[i] = 4'h3;
            end
        end
        dv[0] = dv[1]; did[0] = did[1]; dd[0] = dd[1];
        dv[1] = dv[2]; did[1] = did[2]; dd[1] = dd[2];
        dv[2] = 1'b0;
        e_busy = !rst_n || (clr_left != 0);
        o_va = bus0.rvalid_a; o_vb = bus0.rvalid_b;
        o_da = bus0.rdata_a;  o_db = bus0.rdata_b;
        o_busy = bus0.busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) step0();
        n_checks++;
        if ({bus0.ram_rst, bus0.ram_en, bus0.ram_we, bus0.busy} !== 4'b1001) begin
            n_errors++;
            $display("FAIL reset_ctrl rst/en/we/busy got %b exp 1001",
                     {bus0.ram_rst, bus0.ram_en, bus0.ram_we, bus0.busy});
        end
        n_checks++;
        if ({bus0.ram_addr, bus0.ram_di} !== 14'h0) begin
            n_errors++;
            $display("FAIL reset_port addr/di got %h/%h exp 000/0", bus0.ram_addr, bus0.ram_di);
        end
        n_checks++;
        if ({bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_a, bus0.rdata_b} !== 10'h0) begin
            n_errors++;
            $display("FAIL reset_rd rvalid a/b %b%b rdata %h/%h exp 00 0/0",
                     bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_a, bus0.rdata_b);
        end
        rst_n = 1'b1;
        step0();
        n_checks++;
        if (bus0.ram_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL release_ramrst got %b exp 0", bus0.ram_rst);
        end
        n_checks++;
`ifdef RAMB4_S4_ARB_CLEAR_EN
        if (bus0.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL release_busy got %b exp 1", bus0.busy);
        end
`else
        if (bus0.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL release_busy got %b exp 0", bus0.busy);
        end
`endif
    endtask

`ifdef RAMB4_S4_ARB_CLEAR_EN
    task automatic test_clear();
        int k = 1;       // the release edge already issued address 0
        int bad = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000;
        while (o_busy === 1'b1 && k < 1100) begin
            step0();
            k++;
            if (o_ga !== 1'b0) bad++;
            if (bus0.ram_addr !== 10'(k - 1) || bus0.ram_di !== 4'h3 ||
                bus0.ram_en !== 1'b1 || bus0.ram_we !== 1'b1) bad++;
        end
        n_checks++;
        if (k !== 1024) begin
            n_errors++;
            $display("FAIL clear_len busy cycles got %0d exp 1024", k);
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL clear_sweep bad cycles got %0d exp 0", bad);
        end
        step0();                          // read 0x000
        a_addr = 10'h3FF;
        step0();                          // read 0x3FF
        a_req = 1'b0;
        step0();
        n_checks++;
        if ({o_va, o_da} !== 5'h13) begin
            n_errors++;
            $display("FAIL clear_rd000 valid/data got %b/%h exp 1/3", o_va, o_da);
        end
        step0();
        n_checks++;
        if ({o_va, o_da} !== 5'h13) begin
            n_errors++;
            $display("FAIL clear_rd3ff valid/data got %b/%h exp 1/3", o_va, o_da);
        end
        step0();
    endtask
`endif

    task automatic test_write_read();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_di = 4'hA;
        step0();
        n_checks++;
        if (o_ga !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_gnt got %b exp 1", o_ga);
        end
        n_checks++;
        if ({bus0.ram_en, bus0.ram_we, bus0.ram_addr, bus0.ram_di} !== {2'b11, 10'h005, 4'hA}) begin
            n_errors++;
            $display("FAIL wr_issue en/we/addr/di got %b%b/%h/%h exp 11/005/a",
                     bus0.ram_en, bus0.ram_we, bus0.ram_addr, bus0.ram_di);
        end
        a_we = 1'b0;
        step0();
        n_checks++;
        if (o_ga !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_gnt got %b exp 1", o_ga);
        end
        a_req = 1'b0;
        step0();
        n_checks++;
        if ({bus0.ram_en, bus0.ram_we, bus0.ram_addr, o_va} !== {2'b00, 10'h005, 1'b0}) begin
            n_errors++;
            $display("FAIL rd_idle en/we/addr/rvalid got %b%b/%h/%b exp 00/005/0",
                     bus0.ram_en, bus0.ram_we, bus0.ram_addr, o_va);
        end
        step0();
        n_checks++;
        if ({o_va, o_da} !== 5'h1A) begin
            n_errors++;
            $display("FAIL rd_return valid/data got %b/%h exp 1/a", o_va, o_da);
        end
        step0();
        n_checks++;
        if ({o_va, o_da} !== 5'h0A) begin
            n_errors++;
            $display("FAIL rd_hold valid/data got %b/%h exp 0/a", o_va, o_da);
        end
    endtask

    task automatic test_round_robin();
        int na = 0, nb = 0;
        logic prev_ga = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 10'(16 + k); a_di = 4'($urandom);
            step0();
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd16;
        b_req = 1'b1; b_we = 1'b0; b_addr = 10'd17;
        for (int k = 0; k < 9; k++) begin
            step0();
            n_checks++;
            if ({o_ga, o_gb, o_va, o_vb, o_da, o_db, o_busy} !== {e_ga, e_gb, e_va, e_vb, e_da, e_db, e_busy}) begin
                n_errors++;
                $display("FAIL rr_step%0d g=%b%b v=%b%b d=%h%h busy=%b exp g=%b%b v=%b%b d=%h%h busy=%b",
                         k, o_ga, o_gb, o_va, o_vb, o_da, o_db, o_busy, e_ga, e_gb, e_va, e_vb, e_da, e_db, e_busy);
            end
            if (k > 0 && k < 6) begin
                n_checks++;
                if (o_ga === prev_ga) begin
                    n_errors++;
                    $display("FAIL rr_alternate step%0d gnt_a got %b exp %b", k, o_ga, !prev_ga);
                end
            end
            prev_ga = o_ga;
            if (e_ga) begin na++; a_addr = a_addr + 10'd2; if (na == 3) a_req = 1'b0; end
            if (e_gb) begin nb++; b_addr = b_addr + 10'd2; if (nb == 3) b_req = 1'b0; end
        end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        bus1.req_a = 1'b1; bus1.we_a = 1'b0; bus1.addr_a = 10'($urandom); bus1.di_a = 4'h0;
        bus1.req_b = 1'b1; bus1.we_b = 1'b0; bus1.addr_b = 10'($urandom); bus1.di_b = 4'h0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({bus1.gnt_a, bus1.gnt_b} !== 2'b10) begin
                n_errors++;
                $display("FAIL fixed_tie%0d gnt a/b got %b%b exp 10", k, bus1.gnt_a, bus1.gnt_b);
            end
        end
        @(negedge clk);
        bus1.req_a = 1'b0;
        #1;
        n_checks++;
        if ({bus1.gnt_a, bus1.gnt_b} !== 2'b01) begin
            n_errors++;
            $display("FAIL fixed_drop_a gnt a/b got %b%b exp 01", bus1.gnt_a, bus1.gnt_b);
        end
        @(negedge clk);
        bus1.req_b = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
        step0();
        a_req = 1'b0;
        rst_n = 1'b0;
        step0();
        rst_n = 1'b1;
        for (int k = 0; k < 1100 && (k < 4 || clr_left != 0); k++) begin
            step0();
            n_checks++;
            if ({o_va, o_vb} !== 2'b00) begin
                n_errors++;
                $display("FAIL rst_discard step%0d rvalid a/b got %b%b exp 00", k, o_va, o_vb);
            end
        end
        a_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step0();
            a_req = 1'b0;
            n_checks++;
            if ({o_ga, o_va, o_da} !== {e_ga, e_va, e_da}) begin
                n_errors++;
                $display("FAIL rst_reread step%0d g/v/d got %b/%b/%h exp %b/%b/%h",
                         k, o_ga, o_va, o_da, e_ga, e_va, e_da);
            end
        end
    endtask

    task automatic test_random();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1;
        for (int k = 0; k < 32; k++) begin
            a_addr = 10'(k); a_di = 4'($urandom);
            step0();
        end
        a_req = 1'b0;
        for (int n = 0; n < 303; n++) begin
            if (n < 300) begin
                if (!a_req && $urandom_range(0, 9) < 7) begin
                    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_addr = 10'($urandom_range(0, 31)); a_di = 4'($urandom);
                end
                if (!b_req && $urandom_range(0, 9) < 7) begin
                    b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                    b_addr = 10'($urandom_range(0, 31)); b_di = 4'($urandom);
                end
            end
            step0();
            n_checks++;
            if ({o_ga, o_gb, o_va, o_vb, o_da, o_db, o_busy} !== {e_ga, e_gb, e_va, e_vb, e_da, e_db, e_busy}) begin
                n_errors++;
                $display("FAIL rand_step%0d g=%b%b v=%b%b d=%h%h busy=%b exp g=%b%b v=%b%b d=%h%h busy=%b",
                         n, o_ga, o_gb, o_va, o_vb, o_da, o_db, o_busy, e_ga, e_gb, e_va, e_vb, e_da, e_db, e_busy);
            end
            if (e_ga) a_req = 1'b0;
            if (e_gb) b_req = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.req_a = 1'b0; bus1.we_a = 1'b0; bus1.addr_a = '0; bus1.di_a = '0;
        bus1.req_b = 1'b0; bus1.we_b = 1'b0; bus1.addr_b = '0; bus1.di_b = '0;
        test_reset();
`ifdef RAMB4_S4_ARB_CLEAR_EN
        test_clear();
`endif
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ramb4_s4_arb.md
Name: ramb4_s4_arb

Overview:
Two-requester round-robin arbiter and sequencer for one single-port 1024x4 block RAM (RAMB4_S4 class). It accepts one access per cycle from requester A or B, drives the RAM port from registers, and returns read data to the winning requester with a fixed latency. It sits between two client FSMs and the RAM primitive and is the only driver of the RAM's ADDR/DI/EN/WE/RST.

Parameters:
ARB_MODE, 0, 0 = round-robin on tie; 1 = fixed priority, A always wins a tie
CLR_DATA, 4'h0, word written to every address by the optional clear sweep

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  synchronous active-low reset
REQ_A  input  1  requester A access request
WE_A  input  1  A: 1 = write, 0 = read
ADDR_A  input  10  A word address
DI_A  input  4  A write data
GNT_A  output  1  A request accepted this cycle (combinational)
RVALID_A  output  1  A read data valid (registered, 1-cycle pulse)
RDATA_A  output  4  A read data (registered)
REQ_B, WE_B, ADDR_B, DI_B, GNT_B, RVALID_B, RDATA_B  as for A, requester B
RAM_ADDR  output  10  to RAM ADDR (registered)
RAM_DI  output  4  to RAM DI (registered)
RAM_EN  output  1  to RAM EN (registered)
RAM_WE  output  1  to RAM WE (registered)
RAM_RST  output  1  to RAM RST (registered)
RAM_DO  input  4  from RAM DO
BUSY  output  1  high while the block does not accept requests

Behaviour:
- Reset (RST_N=0 at an edge): RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0, RAM_RST=1; RVALID_A/B=0, RDATA_A/B=0; last-grant register = B, so A wins the first tie; read pipeline cleared; state = RUN (CLEAR with macro). BUSY=1 during reset. The first edge with RST_N=1 sets RAM_RST=0.
- Reset mid-operation: in-flight reads are discarded and no RVALID is issued for them.
- States: CLEAR (macro only) -> RUN. In RUN, BUSY=0.
- Arbitration (RUN, cycle t):
  - Only REQ_A -> GNT_A.
  - Only REQ_B -> GNT_B.
  - Both -> ARB_MODE=0 grants the requester not in last-grant; ARB_MODE=1 grants A.
  - GNT_A and GNT_B are mutually exclusive. At most one grant per cycle; no bubble between back-to-back grants.
  - Last-grant updates only on a grant.
  - A requester holds REQ/WE/ADDR/DI stable until it sees GNT. The losing request stays pending.
- Issue: on the edge ending cycle t, the winner's ADDR/DI/WE load into RAM_ADDR/RAM_DI/RAM_WE and RAM_EN=1. With no grant, RAM_EN=0 and RAM_WE=0; RAM_ADDR and RAM_DI hold.
- Read return: a granted read in cycle t makes RAM_DO valid in t+2. On that edge, RDATA_x <= RAM_DO and RVALID_x=1 in cycle t+3 for one cycle. Latency is GNT to RVALID = 3 cycles.
- A 2-deep tag pipeline (valid + requester id) tracks in-flight reads. Back-to-back reads return in order, one per cycle.
- RDATA_x holds its last value when RVALID_x=0.
- Writes produce no RVALID. The RAM is write-first, and its DO during a write cycle is ignored.
- Read-after-write to the same address in consecutive grants returns the new data; no hazard logic is needed.
- Addresses 0..1023 are all legal; there is no wrap logic.

Optional Feature:
Macro RAMB4_S4_ARB_CLEAR_EN.
- Defined: after reset the block enters CLEAR. A 10-bit counter sweeps address 0..1023 with RAM_EN=1, RAM_WE=1, RAM_DI=CLR_DATA, one address per cycle. BUSY=1 and GNT_A/B=0 throughout. After address 1023 is issued, the block moves to RUN; BUSY falls in the next cycle (1024 cycles after reset release). Asserting reset mid-sweep restarts the sweep at 0.
- Undefined: no CLEAR state or counter. The block enters RUN directly and BUSY is 0 from the first cycle after reset release.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles -> RAM_RST=1, RAM_EN=0, RVALID=0, BUSY=1; first edge after release -> RAM_RST=0; BUSY=0 (macro off).
- A writes 4'hA to 10'h005, then reads 10'h005 -> GNT_A each cycle; RVALID_A with RDATA_A=4'hA exactly 3 cycles after the read GNT.
- A and B both request reads every cycle for 6 cycles (ARB_MODE=0) -> grants alternate A,B,A,B,A,B; RVALIDs return in the same order with the correct data.
- ARB_MODE=1 with both requesting continuously -> GNT_A every cycle, GNT_B never. Drop REQ_A -> GNT_B in the same cycle.
- Assert RST_N=0 one cycle after a read GNT -> no RVALID follows; post-reset reads return correct data.
- Macro on, CLR_DATA=4'h3 -> BUSY=1 for 1024 cycles with REQ_A ignored; after that, reads of 10'h000 and 10'h3FF return 4'h3.
